// File: rtl/tlp_header_builder_if.sv
// Request and TX stream bundles for the TLP header builder.
// Each bundle has a master (driver) and a slave (receiver) modport.
interface tlp_req_if;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_type;
  logic [31:0] req_addr;
  logic [9:0]  req_length;
  logic [7:0]  req_tag;
  logic [15:0] req_requester_id;
  logic [31:0] req_data;

  modport master (
    output req_valid, req_type, req_addr, req_length, req_tag, req_requester_id, req_data,
    input  req_ready
  );
  modport slave (
    input  req_valid, req_type, req_addr, req_length, req_tag, req_requester_id, req_data,
    output req_ready
  );
endinterface

interface tlp_tx_if;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sop;
  logic        tx_eop;

  modport master (
    output tx_data, tx_valid, tx_sop, tx_eop,
    input  tx_ready
  );
  modport slave (
    input  tx_data, tx_valid, tx_sop, tx_eop,
    output tx_ready
  );
endinterface

// File: rtl/tlp_header_builder.sv
// Builds a 3DW PCIe TLP header (plus optional 1DW payload) from a one-hot
// request kind and streams it as 32-bit beats over valid/ready.
module tlp_header_builder #(
  parameter logic [15:0] COMPLETER_ID = 16'h0000,
  parameter logic [2:0]  TC           = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  tlp_req_if.slave    req,
  tlp_tx_if.master    tx,
  output logic        err_type,
  output logic [15:0] tlp_count
);

  localparam int unsigned DW_W  = 32;
  localparam int unsigned LEN_W = 10;

  typedef enum logic [2:0] {IDLE, H0, H1, H2, DATA} state_t;

  state_t            state;
  logic [DW_W-1:0]   dw1_q;
  logic [DW_W-1:0]   dw2_q;
  logic [DW_W-1:0]   data_q;
  logic              payload_q;

  logic              one_hot_c;
  logic              is_mem_c;
  logic              is_cfg_c;
  logic              is_cpl_c;
  logic              payload_c;
  logic [7:0]        fmt_type_c;
  logic [LEN_W-1:0]  len_c;
  logic [3:0]        last_be_c;
  logic [11:0]       byte_count_c;
  logic [DW_W-1:0]   dw0_c;
  logic [DW_W-1:0]   dw1_c;
  logic [DW_W-1:0]   dw2_c;

  // Header words derived straight from the request inputs; captured on acceptance.
  always_comb begin
    one_hot_c  = (req.req_type != '0) &&
                 ((req.req_type & (req.req_type - LEN_W'(1))) == '0);
    is_mem_c   = |req.req_type[1:0];
    is_cfg_c   = |req.req_type[7:4];
    is_cpl_c   = |req.req_type[9:8];
    payload_c  = req.req_type[3] | req.req_type[5] | req.req_type[7] | req.req_type[9];

    fmt_type_c = 8'h00;
    if      (req.req_type[1]) fmt_type_c = 8'h01;
    else if (req.req_type[2]) fmt_type_c = 8'h02;
    else if (req.req_type[3]) fmt_type_c = 8'h42;
    else if (req.req_type[4]) fmt_type_c = 8'h04;
    else if (req.req_type[5]) fmt_type_c = 8'h44;
    else if (req.req_type[6]) fmt_type_c = 8'h05;
    else if (req.req_type[7]) fmt_type_c = 8'h45;
    else if (req.req_type[8]) fmt_type_c = 8'h0A;
    else if (req.req_type[9]) fmt_type_c = 8'h4A;

    if (is_mem_c)              len_c = req.req_length;
    else if (req.req_type[8])  len_c = LEN_W'(0);
    else                       len_c = LEN_W'(1);

    // len==0 on a memory read means 1024 DW, so it naturally takes last_be=F.
    last_be_c    = (len_c == LEN_W'(1)) ? 4'h0 : 4'hF;
    byte_count_c = req.req_type[9] ? 12'd4 : 12'd0;

    dw0_c = {fmt_type_c, 1'b0, TC, 4'b0000, 6'b000000, len_c};

    if (is_cpl_c) dw1_c = {COMPLETER_ID, 3'b000, 1'b0, byte_count_c};
    else          dw1_c = {req.req_requester_id, req.req_tag, last_be_c, 4'hF};

    if (is_cfg_c)      dw2_c = {req.req_addr[31:16], 4'b0000, req.req_addr[11:2], 2'b00};
    else if (is_cpl_c) dw2_c = {req.req_requester_id, req.req_tag, 1'b0, req.req_addr[6:0]};
    else               dw2_c = {req.req_addr[31:2], 2'b00};
  end

  // Serialiser FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      req.req_ready <= 1'b0;
      tx.tx_valid   <= 1'b0;
      tx.tx_sop     <= 1'b0;
      tx.tx_eop     <= 1'b0;
      tx.tx_data    <= '0;
      err_type      <= 1'b0;
      tlp_count     <= '0;
      dw1_q         <= '0;
      dw2_q         <= '0;
      data_q        <= '0;
      payload_q     <= 1'b0;
    end else begin
      err_type <= 1'b0;
      case (state)
        IDLE: begin
          req.req_ready <= 1'b1;
          if (req.req_ready && req.req_valid) begin
            dw1_q     <= dw1_c;
            dw2_q     <= dw2_c;
            data_q    <= req.req_data;
            payload_q <= payload_c;
            if (one_hot_c) begin
              state         <= H0;
              req.req_ready <= 1'b0;
              tx.tx_valid   <= 1'b1;
              tx.tx_sop     <= 1'b1;
              tx.tx_eop     <= 1'b0;
              tx.tx_data    <= dw0_c;
            end else begin
              err_type <= 1'b1;
            end
          end
        end
        H0: if (tx.tx_valid && tx.tx_ready) begin
          state      <= H1;
          tx.tx_sop  <= 1'b0;
          tx.tx_data <= dw1_q;
        end
        H1: if (tx.tx_valid && tx.tx_ready) begin
          state      <= H2;
          tx.tx_data <= dw2_q;
          tx.tx_eop  <= !payload_q;
        end
        H2: if (tx.tx_valid && tx.tx_ready) begin
          if (payload_q) begin
            state      <= DATA;
            tx.tx_data <= data_q;
            tx.tx_eop  <= 1'b1;
          end else begin
            state         <= IDLE;
            req.req_ready <= 1'b1;
            tx.tx_valid   <= 1'b0;
            tx.tx_eop     <= 1'b0;
            tx.tx_data    <= '0;
            tlp_count     <= tlp_count + 16'd1;
          end
        end
        DATA: if (tx.tx_valid && tx.tx_ready) begin
          state         <= IDLE;
          req.req_ready <= 1'b1;
          tx.tx_valid   <= 1'b0;
          tx.tx_eop     <= 1'b0;
          tx.tx_data    <= '0;
          tlp_count     <= tlp_count + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlp_header_builder.sv
// Randomised and directed bench for tlp_header_builder, checked against a
// packet-level reference model of the header layout rules.
module tb_tlp_header_builder;

  localparam logic [15:0] CID = 16'hABCD;
  localparam logic [2:0]  TCV = 3'b000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        err_type;
  logic [15:0] tlp_count;

  tlp_req_if req ();
  tlp_tx_if  tx ();

  tlp_header_builder #(.COMPLETER_ID(CID), .TC(TCV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req.slave),
    .tx        (tx.master),
    .err_type  (err_type),
    .tlp_count (tlp_count)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          err_seen = 0;
  int          valid_cycles = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [33:0] obs_q[$];
  logic [33:0] exp_q[$];
  int          bp_mode = 0;
  int          pidx = 0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_beat = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // tx_ready: 0 = always ready, 1 = random, 2 = 1,0,0,1 pattern, 3 = stalled
  always @(posedge clk) begin
    #1;
    pidx++;
    case (bp_mode)
      0:       tx.tx_ready = 1'b1;
      1:       tx.tx_ready = 1'($urandom_range(0, 1));
      2:       tx.tx_ready = ((pidx % 4) == 0) || ((pidx % 4) == 3);
      default: tx.tx_ready = 1'b0;
    endcase
  end

  // Beat monitor: handshakes, stall stability, valid and error activity.
  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      check("hold_valid", 32'(tx.tx_valid), 32'd1);
      check("hold_data", tx.tx_data, prev_beat[31:0]);
      check("hold_flags", 32'({tx.tx_sop, tx.tx_eop}), 32'(prev_beat[33:32]));
    end
    prev_stall = rst_n && tx.tx_valid && !tx.tx_ready;
    prev_beat  = {tx.tx_sop, tx.tx_eop, tx.tx_data};
    if (rst_n && tx.tx_valid && tx.tx_ready) obs_q.push_back({tx.tx_sop, tx.tx_eop, tx.tx_data});
    if (rst_n && tx.tx_valid) valid_cycles++;
    if (rst_n && err_type) err_seen++;
  end

  // Expected packet from the header layout rules, as {sop, eop, dw} entries.
  task automatic model(input logic [9:0] t, input logic [31:0] a, input logic [9:0] l,
                       input logic [7:0] tg, input logic [15:0] rid, input logic [31:0] d,
                       output int n);
    logic [7:0]  ft [10] = '{8'h00, 8'h01, 8'h02, 8'h42, 8'h04, 8'h44, 8'h05, 8'h45, 8'h0A, 8'h4A};
    int          k;
    logic [31:0] len, bc, lbe, dw0, dw1, dw2;
    logic        payload, mem, cfg, cpl;
    exp_q.delete();
    k = 0;
    for (int i = 0; i < 10; i++) if (t[i]) k = i;
    payload = ft[k][6];
    mem     = (k < 2);
    cfg     = (k >= 4) && (k < 8);
    cpl     = (k >= 8);
    len     = mem ? 32'(l) : ((k == 8) ? 32'd0 : 32'd1);
    bc      = (k == 9) ? 32'd4 : 32'd0;
    lbe     = (len == 32'd1) ? 32'd0 : 32'd15;
    dw0     = (32'(ft[k]) << 24) | (32'(TCV) << 20) | len;
    dw1     = cpl ? ((32'(CID) << 16) | bc)
                  : ((32'(rid) << 16) | (32'(tg) << 8) | (lbe << 4) | 32'd15);
    if (cfg)      dw2 = a & 32'hFFFF_0FFC;
    else if (cpl) dw2 = (32'(rid) << 16) | (32'(tg) << 8) | (a & 32'h7F);
    else          dw2 = a & 32'hFFFF_FFFC;
    exp_q.push_back({2'b10, dw0});
    exp_q.push_back({2'b00, dw1});
    exp_q.push_back({1'b0, !payload, dw2});
    if (payload) exp_q.push_back({2'b01, d});
    n = payload ? 4 : 3;
  endtask

  task automatic scramble_req();
    req.req_type         = 10'($urandom);
    req.req_addr         = $urandom;
    req.req_length       = 10'($urandom);
    req.req_tag          = 8'($urandom);
    req.req_requester_id = 16'($urandom);
    req.req_data         = $urandom;
  endtask

  // Present one request and drop it (with scrambled fields) once accepted.
  task automatic issue(input logic [9:0] t, input logic [31:0] a, input logic [9:0] l,
                       input logic [7:0] tg, input logic [15:0] rid, input logic [31:0] d);
    bit got = 1'b0;
    @(posedge clk); #1;
    req.req_valid = 1'b1;
    req.req_type = t; req.req_addr = a; req.req_length = l;
    req.req_tag = tg; req.req_requester_id = rid; req.req_data = d;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req.req_ready) begin got = 1'b1; break; end
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req.req_valid = 1'b0;
    scramble_req();
  endtask

  task automatic run_tlp(input logic [9:0] t, input logic [31:0] a, input logic [9:0] l,
                         input logic [7:0] tg, input logic [15:0] rid, input logic [31:0] d);
    int n, e0, v0;
    bit legal;
    legal = ($countones(t) == 1);
    if (legal) model(t, a, l, tg, rid, d, n);
    obs_q.delete();
    e0 = err_seen;
    issue(t, a, l, tg, rid, d);
    if (legal) begin
      exp_cnt = exp_cnt + 16'd1;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (obs_q.size() >= n) break;
      end
      @(negedge clk);
      check("beat_count", 32'(obs_q.size()), 32'(n));
      for (int i = 0; i < n && i < obs_q.size(); i++) begin
        check($sformatf("dw%0d", i), obs_q[i][31:0], exp_q[i][31:0]);
        check($sformatf("sop_eop%0d", i), 32'(obs_q[i][33:32]), 32'(exp_q[i][33:32]));
      end
      check("tlp_count", 32'(tlp_count), 32'(exp_cnt));
      check("no_err", 32'(err_seen - e0), 32'd0);
    end else begin
      v0 = valid_cycles;
      repeat (3) @(negedge clk);
      check("err_pulse", 32'(err_seen - e0), 32'd1);
      check("illegal_no_valid", 32'(valid_cycles - v0), 32'd0);
      check("illegal_count", 32'(tlp_count), 32'(exp_cnt));
    end
  endtask

  initial begin
    logic [9:0] t;
    logic [9:0] l;
    int         k;
    rst_n = 1'b0;
    bp_mode = 0;
    tx.tx_ready = 1'b1;
    scramble_req();
    req.req_valid = 1'b1;

    // Reset held with a request pending.
    repeat (3) begin
      @(negedge clk);
      check("rst_valid", 32'(tx.tx_valid), 32'd0);
      check("rst_count", 32'(tlp_count), 32'd0);
      check("rst_ready", 32'(req.req_ready), 32'd0);
      check("rst_err", 32'(err_type), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    req.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", 32'(req.req_ready), 32'd1);
    check("no_beats_after_rst", 32'(valid_cycles), 32'd0);

    // Directed packets.
    run_tlp(10'h001, 32'h1234_5678, 10'd4, 8'h07, 16'h0100, 32'h0);
    run_tlp(10'h008, 32'h0000_0010, 10'd9, 8'h01, 16'h0200, 32'hDEAD_BEEF);
    bp_mode = 2; pidx = 0;
    run_tlp(10'h200, 32'h0000_0004, 10'd0, 8'h05, 16'h0100, 32'h1111_2222);
    bp_mode = 0;
    run_tlp(10'h003, 32'h0, 10'd1, 8'h00, 16'h0, 32'h0);
    run_tlp(10'h000, 32'h0, 10'd1, 8'h00, 16'h0, 32'h0);
    run_tlp(10'h002, 32'h0, 10'd0, 8'h11, 16'h0300, 32'h0);
    run_tlp(10'h010, 32'hABCD_F87B, 10'd3, 8'h22, 16'h0400, 32'h0);
    run_tlp(10'h100, 32'hFFFF_FFFF, 10'd7, 8'h33, 16'h0500, 32'h0);

    // Randomised traffic with mixed backpressure.
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 11);
      t = (k < 10) ? 10'(1 << k) : 10'($urandom);
      l = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1)) : 10'($urandom);
      bp_mode = $urandom_range(0, 1);
      run_tlp(t, $urandom, l, 8'($urandom), 16'($urandom), $urandom);
    end
    bp_mode = 0;

    // Counter wrap.
    @(negedge clk);
    force dut.tlp_count = 16'hFFFF;
    @(posedge clk); #1;
    release dut.tlp_count;
    exp_cnt = 16'hFFFF;
    run_tlp(10'h100, 32'h0000_0042, 10'd0, 8'h44, 16'h0600, 32'h0);
    check("wrap_zero", 32'(tlp_count), 32'd0);

    // Reset while the header is mid-flight in H1.
    bp_mode = 3;
    obs_q.delete();
    @(posedge clk); #1;
    req.req_valid = 1'b1;
    req.req_type = 10'h001; req.req_addr = 32'h0BAD_F00D; req.req_length = 10'd2;
    req.req_tag = 8'h09; req.req_requester_id = 16'h0700; req.req_data = 32'h0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx.tx_valid && tx.tx_sop) break;
    end
    req.req_valid = 1'b0;
    check("mid_h0", 32'({tx.tx_valid, tx.tx_sop}), 32'd3);
    bp_mode = 0;
    @(posedge clk);
    @(posedge clk);
    bp_mode = 3;
    @(negedge clk);
    check("mid_h1", 32'({tx.tx_valid, tx.tx_sop, tx.tx_eop}), 32'b100);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", 32'(tx.tx_valid), 32'd0);
    check("mid_rst_eop", 32'(tx.tx_eop), 32'd0);
    check("mid_rst_count", 32'(tlp_count), 32'd0);
    check("mid_rst_beats", 32'(obs_q.size()), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bp_mode = 0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_idle", 32'(req.req_ready), 32'd1);
    check("mid_rst_no_valid", 32'(tx.tx_valid), 32'd0);
    exp_cnt = 16'd0;
    run_tlp(10'h020, 32'h0012_0344, 10'd0, 8'h0C, 16'h0800, 32'hCAFE_0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tlp_header_builder.md
Name: tlp_header_builder

Overview:
- Transmit-side counterpart of the TLP fmt/type decoder: takes a one-hot TLP kind plus request fields and serialises a 3DW PCIe header, with an optional 1DW payload, onto a 32-bit valid/ready stream.
- One-hot bit order is the same as the decoder output: bit0 MRd32, bit1 MRdLk, bit2 IORd, bit3 IOWr, bit4 CfgRd0, bit5 CfgWr0, bit6 CfgRd1, bit7 CfgWr1, bit8 Cpl, bit9 CplD.
- Sits between request-generation logic and the TX link interface.

Parameters:
- COMPLETER_ID, 16'h0000, completer ID inserted in completion DW1.
- TC, 3'b000, traffic class inserted in DW0 bits[22:20].

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  builder can accept a request.
- req_type  in  10  one-hot TLP kind.
- req_addr  in  32  memory/IO address; for Cfg, [31:16]=BDF and [11:2]=register; for Cpl/CplD, [6:0]=lower address.
- req_length  in  10  DW length; used for MRd32/MRdLk only.
- req_tag  in  8  tag.
- req_requester_id  in  16  requester ID; for completions, the original requester.
- req_data  in  32  payload DW for IOWr, CfgWr0, CfgWr1 and CplD.
- tx_data  out  32  stream beat.
- tx_valid  out  1  beat valid.
- tx_ready  in  1  sink accepts beat.
- tx_sop  out  1  first beat of a TLP.
- tx_eop  out  1  last beat of a TLP.
- err_type  out  1  one-cycle pulse: request dropped because req_type was not one-hot.
- tlp_count  out  16  TLPs fully sent; wraps from 0xFFFF to 0.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE. tx_valid, tx_sop, tx_eop, err_type, tlp_count and tx_data are all 0. req_ready is 0 during reset and 1 in the cycle after release.
  - Reset mid-TLP abandons the packet; no eop is issued.
- States are IDLE, H0, H1, H2 and DATA. req_ready is 1 only in IDLE.
- IDLE:
  - Accepts a request when req_valid is high. All req_* fields are registered at that edge.
  - If req_type has exactly one bit set, the next state is H0.
  - Otherwise err_type pulses for one cycle, the state stays IDLE and nothing is transmitted.
- In H0, H1, H2 and DATA, tx_valid is 1. The state advances only on tx_valid && tx_ready; with tx_ready low, tx_data, tx_sop and tx_eop hold stable.
- Fmt/type byte values:
  - MRd32 8'h00, MRdLk 8'h01, IORd 8'h02, IOWr 8'h42.
  - CfgRd0 8'h04, CfgWr0 8'h44, CfgRd1 8'h05, CfgWr1 8'h45.
  - Cpl 8'h0A, CplD 8'h4A.
- Length (len):
  - MRd32 and MRdLk use req_length; the value 0 passes through unchanged and means 1024 DW.
  - CplD, IO and Cfg types use 1.
  - Cpl uses 0.
- H0 (tx_sop=1): DW0 = {fmt_type[7:0], 1'b0, TC, 4'b0, 6'b0, len[9:0]}.
- H1:
  - Requests: {req_requester_id, req_tag, last_be, first_be}.
  - first_be = 4'hF.
  - last_be = 4'h0 if len==1, else 4'hF; for MRd with len==0, last_be = 4'hF.
  - Completions: {COMPLETER_ID, 3'b000, 1'b0, byte_count[11:0]}. byte_count = 12'd4 for CplD and 12'd0 for Cpl.
- H2:
  - MRd and IO: {req_addr[31:2], 2'b00}.
  - Cfg: {req_addr[31:16], 4'b0, req_addr[11:2], 2'b00}.
  - Completions: {req_requester_id, req_tag, 1'b0, req_addr[6:0]}.
  - tx_eop=1 if the type carries no payload.
- DATA (payload types only): tx_data = registered req_data, tx_eop=1.
- Completing a TLP:
  - On acceptance of the eop beat, the state returns to IDLE and tlp_count increments.
  - Minimum period is 4 cycles per no-payload TLP and 5 per payload TLP; a one-cycle IDLE bubble always separates TLPs.
- Inputs changing after acceptance have no effect on the packet in flight.

Test Plan:
- Reset: hold rst_n low 3 cycles while driving req_valid=1 and tx_ready=1 -> tx_valid=0, tlp_count=0, no beats; req_ready=1 in the first cycle after release.
- MRd32: req_type=10'h001, addr 32'h1234_5678, length 4, tag 8'h07, RID 16'h0100, tx_ready=1 -> beats 32'h0000_0004 (sop), 32'h0100_07FF, 32'h1234_5678 (eop); tlp_count=1.
- IOWr: req_type=10'h008, addr 32'h0000_0010, data 32'hDEAD_BEEF, tag 8'h01, RID 16'h0200 -> beats 32'h4200_0001, 32'h0200_010F, 32'h0000_0010, then 32'hDEAD_BEEF with eop only on that beat.
- CplD with backpressure: req_type=10'h200, COMPLETER_ID=16'hABCD, RID 16'h0100, tag 8'h05, addr[6:0]=7'h04, data 32'h1111_2222; tx_ready toggling 1,0,0,1 -> beats 32'h4A00_0001, 32'hABCD_0004, 32'h0100_0504, 32'h1111_2222; each beat holds stable while tx_ready=0; exactly 4 handshakes.
- Illegal type: req_type=10'h003, then 10'h000 -> err_type pulses once per request, tx_valid stays 0, tlp_count unchanged.
- Counter wrap and mid-packet reset:
  - Preload tlp_count to 16'hFFFF via 65535 Cpl TLPs (or force in the bench), send one more -> tlp_count=0.
  - Assert rst_n=0 during H1 -> tx_valid=0 on the next cycle, no eop, state IDLE.
